// File: rtl/ram_dma.sv
// Single-port RAM DMA engine: copies a block (read then write per word) or fills a block
// with a constant word. Addresses wrap modulo the RAM depth.
module ram_dma #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0] fill_val,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  // state | meaning
  // IDLE  | waiting for start; outputs parked at 0
  // READ  | copy only: address src+i, capture ram_out
  // WRITE | address dst+i, write captured word or fill word
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   i_q, i_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  last_word;

  // One extra bit on the count and index so a zero length means the full RAM depth.
  assign last_word = (i_q == (cnt_q - {{ADDR_WIDTH{1'b0}}, 1'b1}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      data_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    data_d      = data_q;
    fill_d      = fill_q;
    busy        = 1'b0;
    done        = 1'b0;
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src;
          dst_d   = dst;
          fill_d  = fill_val;
          cnt_d   = (len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, len};
          i_d     = '0;
          state_d = mode ? WRITE : READ;
        end
      end
      READ: begin
        busy        = 1'b1;
        ram_address = src_q + i_q[ADDR_WIDTH-1:0];
        data_d      = ram_out;
        state_d     = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        ram_address = dst_q + i_q[ADDR_WIDTH-1:0];
        ram_load    = 1'b1;
        ram_in      = mode_q ? fill_q : data_q;
        if (last_word) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          state_d = mode_q ? WRITE : READ;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: behavioural RAM plus an array reference model of
// copy/fill results, with cycle-accurate timing checks on busy/done/ram_load.
module tb_ram_dma;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0, dst = '0, len = '0;
  logic [DW-1:0] fill_val = '0;
  logic          busy, done, ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in, ram_out;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  int n_cmp = 0;
  int n_fail = 0;

  ram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  assign ram_out = mem[ram_address];

  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) n++;
    return n;
  endfunction

  // Reference: word j of a command touches (base + j) mod depth, ascending order.
  function automatic void model_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                    input logic [AW-1:0] l, input logic [DW-1:0] f);
    int n = (l == 0) ? DEPTH : int'(l);
    for (int j = 0; j < n; j++) begin
      if (m) ref_mem[(int'(d) + j) % DEPTH] = f;
      else   ref_mem[(int'(d) + j) % DEPTH] = ref_mem[(int'(s) + j) % DEPTH];
    end
  endfunction

  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] f, input bit interfere,
                         output int done_c, output int busy_c, output int load_c,
                         output logic busy_before);
    @(negedge clk);
    busy_before = busy;
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'($urandom); src = AW'($urandom); dst = AW'($urandom);
    len = AW'($urandom); fill_val = DW'($urandom);
    done_c = 0; busy_c = 0; load_c = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (busy) busy_c++;
      if (ram_load) load_c++;
      if (interfere && c == 3) begin
        start = 1'b1; mode = 1'b1; dst = AW'($urandom); len = 8'd20; fill_val = 16'hDEAD;
      end
      if (c == 4) start = 1'b0;
      if (done) begin
        done_c = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (ram_load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", ram_load); end
    n_cmp++; if (ram_address !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", ram_address); end
    n_cmp++; if (ram_in !== 16'h0000) begin n_fail++; $display("FAIL reset_in: got %h want 0000", ram_in); end
    start = 1'b1; mode = 1'b1; len = 8'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_holds_idle: busy got %b want 0", busy); end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic init_mem();
    for (int k = 0; k < DEPTH; k++) bd_write(AW'(k), DW'($urandom));
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL init_mem: %0d words differ want 0", mem_diff()); end
  endtask

  task automatic test_copy();
    int dc, bc, lc; logic bb;
    for (int k = 10; k < 14; k++) bd_write(AW'(k), DW'($urandom));
    run_cmd(1'b0, 8'd10, 8'd100, 8'd4, 16'h0, 1'b0, dc, bc, lc, bb);
    model_cmd(1'b0, 8'd10, 8'd100, 8'd4, 16'h0);
    n_cmp++; if (bb !== 1'b0) begin n_fail++; $display("FAIL copy_idle_before: busy got %b want 0", bb); end
    n_cmp++; if (dc !== 9) begin n_fail++; $display("FAIL copy_done_cycle: got %0d want 9", dc); end
    n_cmp++; if (bc !== 9) begin n_fail++; $display("FAIL copy_busy_cycles: got %0d want 9", bc); end
    n_cmp++; if (lc !== 4) begin n_fail++; $display("FAIL copy_writes: got %0d want 4", lc); end
    n_cmp++; if (mem[103] !== ref_mem[13]) begin n_fail++; $display("FAIL copy_word3: got %h want %h", mem[103], ref_mem[13]); end
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL copy_mem: %0d words differ want 0", mem_diff()); end
  endtask

  task automatic test_fill_wrap();
    int dc, bc, lc; logic bb;
    run_cmd(1'b1, 8'd0, 8'd254, 8'd4, 16'h5A5A, 1'b0, dc, bc, lc, bb);
    model_cmd(1'b1, 8'd0, 8'd254, 8'd4, 16'h5A5A);
    n_cmp++; if (dc !== 5) begin n_fail++; $display("FAIL fill_done_cycle: got %0d want 5", dc); end
    n_cmp++; if (bc !== 5) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d want 5", bc); end
    n_cmp++; if (mem[1] !== 16'h5A5A) begin n_fail++; $display("FAIL fill_wrap_word: got %h want 5a5a", mem[1]); end
    n_cmp++; if (mem[2] !== ref_mem[2]) begin n_fail++; $display("FAIL fill_beyond_end: got %h want %h", mem[2], ref_mem[2]); end
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL fill_mem: %0d words differ want 0", mem_diff()); end
  endtask

  task automatic test_len0_fill();
    int dc, bc, lc, nf; logic bb;
    run_cmd(1'b1, 8'd0, 8'd0, 8'd0, 16'hFFFF, 1'b0, dc, bc, lc, bb);
    model_cmd(1'b1, 8'd0, 8'd0, 8'd0, 16'hFFFF);
    nf = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== 16'hFFFF) nf++;
    n_cmp++; if (lc !== 256) begin n_fail++; $display("FAIL len0_writes: got %0d want 256", lc); end
    n_cmp++; if (dc !== 257) begin n_fail++; $display("FAIL len0_done_cycle: got %0d want 257", dc); end
    n_cmp++; if (nf !== 0) begin n_fail++; $display("FAIL len0_all_ffff: %0d words not ffff want 0", nf); end
  endtask

  task automatic test_overlap();
    int dc, bc, lc; logic bb;
    for (int k = 0; k < 4; k++) bd_write(AW'(k), DW'(k + 1));
    run_cmd(1'b0, 8'd0, 8'd1, 8'd3, 16'h0, 1'b0, dc, bc, lc, bb);
    model_cmd(1'b0, 8'd0, 8'd1, 8'd3, 16'h0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem[k] !== 16'h0001) begin n_fail++; $display("FAIL overlap_word%0d: got %h want 0001", k, mem[k]); end
    end
    n_cmp++; if (dc !== 7) begin n_fail++; $display("FAIL overlap_done_cycle: got %0d want 7", dc); end
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL overlap_mem: %0d words differ want 0", mem_diff()); end
  endtask

  task automatic test_back_to_back();
    int dc, bc, lc; logic bb;
    logic [AW-1:0] s, d;
    s = AW'($urandom); d = AW'($urandom);
    run_cmd(1'b0, s, d, 8'd4, 16'h0, 1'b1, dc, bc, lc, bb);
    model_cmd(1'b0, s, d, 8'd4, 16'h0);
    n_cmp++; if (dc !== 9) begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d want 9", dc); end
    n_cmp++; if (lc !== 4) begin n_fail++; $display("FAIL busy_start_writes: got %0d want 4", lc); end
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL busy_start_mem: %0d words differ want 0", mem_diff()); end
    d = AW'($urandom);
    run_cmd(1'b1, 8'd0, d, 8'd3, 16'h1234, 1'b0, dc, bc, lc, bb);
    model_cmd(1'b1, 8'd0, d, 8'd3, 16'h1234);
    n_cmp++; if (bb !== 1'b0) begin n_fail++; $display("FAIL after_done_idle: busy got %b want 0", bb); end
    n_cmp++; if (dc !== 4) begin n_fail++; $display("FAIL after_done_accept: done cycle got %0d want 4", dc); end
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL after_done_mem: %0d words differ want 0", mem_diff()); end
  endtask

  task automatic test_random();
    int dc, bc, lc, n; logic bb;
    logic m; logic [AW-1:0] s, d, l; logic [DW-1:0] f;
    for (int t = 0; t < 12; t++) begin
      m = 1'($urandom); s = AW'($urandom); d = AW'($urandom);
      l = AW'($urandom_range(1, 40)); f = DW'($urandom);
      n = int'(l);
      run_cmd(m, s, d, l, f, 1'b0, dc, bc, lc, bb);
      model_cmd(m, s, d, l, f);
      n_cmp++; if (dc !== (m ? n + 1 : 2 * n + 1)) begin n_fail++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", t, dc, m ? n + 1 : 2 * n + 1); end
      n_cmp++; if (lc !== n) begin n_fail++; $display("FAIL rand%0d_writes: got %0d want %0d", t, lc, n); end
      n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL rand%0d_mem: %0d words differ want 0", t, mem_diff()); end
    end
  endtask

  task automatic test_reset_mid();
    int dc, bc, lc; logic bb; logic saw_done;
    logic [AW-1:0] d; logic [DW-1:0] f;
    d = AW'($urandom); f = DW'($urandom);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dst = d; len = 8'd8; fill_val = f;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ram_load !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_load: got %b want 1", ram_load); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (ram_load !== 1'b0) begin n_fail++; $display("FAIL midreset_load_async: got %b want 0", ram_load); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_async: got %b want 0", busy); end
    ref_mem[d] = f;
    ref_mem[AW'(d + 8'd1)] = f;
    saw_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %b want 0", saw_done); end
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL midreset_mem: %0d words differ want 0", mem_diff()); end
    run_cmd(1'b1, 8'd0, d, 8'd3, 16'hC0DE, 1'b0, dc, bc, lc, bb);
    model_cmd(1'b1, 8'd0, d, 8'd3, 16'hC0DE);
    n_cmp++; if (dc !== 4) begin n_fail++; $display("FAIL postreset_done_cycle: got %0d want 4", dc); end
    n_cmp++; if (mem_diff() !== 0) begin n_fail++; $display("FAIL postreset_mem: %0d words differ want 0", mem_diff()); end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_copy();
    test_fill_wrap();
    test_len0_fill();
    test_overlap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
